pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed EX→MEM/WB latch. It carries the control triple (wreg, m2reg, wmem), the ALU result and the destination register number between adjacent CPU stages. It adds a valid bit, a ready/valid backpressure handshake, synchronous flush with bubble insertion, an optional 2-entry skid buffer and a saturating stall counter. One instance sits at each stage boundary (ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- DATA_W, 32, width of ALU result / data field
- RN_W, 5, width of destination register number
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single entry, combinational in_ready
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  kill all held entries; bubble next cycle
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_wreg / in_m2reg / in_wmem  in  1 each  control bits
- in_alu  in  DATA_W  ALU result
- in_rn  in  RN_W  destination register
- out_valid  out  1  head entry present
- out_ready  in  1  downstream accepts head
- out_wreg / out_m2reg / out_wmem  out  1 each  control bits, gated by out_valid
- out_alu  out  DATA_W  head ALU result
- out_rn  out  RN_W  head destination register
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Storage: main slot (M) drives outputs; skid slot (S) exists only when SKID=1. Each slot has a valid bit.
- Accept: in_valid && in_ready. Drain: out_valid && out_ready. out_valid = M.valid.
- SKID=1: in_ready = !S.valid (registered).
  - Accept, M empty or draining → load M.
  - Accept, M full and not draining → load S.
  - Drain with S valid → S moves to M. A simultaneous accept cannot occur, because in_ready=0.
- SKID=0: in_ready = !M.valid || out_ready. Accept loads M.
- Neither accept nor drain: all slots hold.
- Control gating: out_wreg/out_m2reg/out_wmem = M.valid & stored bit. A bubble never produces a write enable. out_alu/out_rn hold their last value when invalid.
- Flush: clears M.valid and S.valid and zeroes stored control bits. An input presented in the flush cycle is dropped, even if in_ready=1. out_ready is ignored that cycle. stall_cnt is unaffected.
- stall_cnt: increments when out_valid && !out_ready and no flush; saturates at all-ones.
- Reset: all valid bits 0, all payload fields 0, stall_cnt 0. Reset overrides flush.

## Timing
- Reset values: out_valid=0, out controls=0, out_alu=0, out_rn=0, stall_cnt=0. in_ready=1 after reset, in both modes.
- Latency: an entry accepted at edge N is visible on the outputs after edge N. One-cycle latency.
- Throughput: one entry per cycle while out_ready=1, in both modes.
- SKID=1 backpressure: after out_ready drops, at most one further entry is absorbed into S. in_ready is low in the following cycle.
- In_ready recovery: in_ready returns to 1 the cycle after S drains into M.
- Flush: out_valid=0 and in_ready=1 in the cycle after the flush edge.
- Flush for one cycle empties the stage. No partial state survives.

## Structure
- Shared package pipe_pkg:
  - typedef pipe_ctrl_t, a packed struct of wreg, m2reg, wmem
  - constants DEF_DATA_W=32, DEF_RN_W=5
- Sub-module pipe_slot: payload register with load, clear and valid bit. Instantiated once for M and once for S under generate (SKID).
- Top level holds the handshake steering and the stall counter.

## Test plan
- Reset then stream: rst=1 for 2 cycles, then in_valid=1 with alu=0x00000001..0x00000004, rn=1..4, wreg=1, out_ready=1. Required: outputs show each value one cycle later, in order, with no gaps, and in_ready stays 1.
- Backpressure with SKID=1: out_ready=0 after entry alu=0xA. Required: entry 0xB is absorbed into S, then in_ready=0. With out_ready=1, out sees 0xA then 0xB and in_ready returns to 1. With SKID=0, in_ready=0 immediately and no entry is lost.
- Flush mid-stall: M and S both full, flush=1 with in_valid=1 and alu=0xC. Required next cycle: out_valid=0, out_wreg=0, in_ready=1, and 0xC is never emitted.
- Bubble gating: in_valid=0 with in_wreg=1 and in_wmem=1 held. Required: out_wreg=out_wmem=0 throughout.
- Stall counter: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles. Required: stall_cnt reaches 15 and stays there. After rst, stall_cnt=0.
- Reset mid-operation: rst asserted while S is valid, together with flush. Required: all outputs 0 and in_ready=1 the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline stage registers.
// Control triple carried alongside every stage payload.
package pipe_pkg;

  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic wmem;
  } pipe_ctrl_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_RN_W   = 5;
  localparam int CTRL_W     = $bits(pipe_ctrl_t);

endpackage

// File: rtl/pipe_slot.sv
// One payload slot of a stage register: valid bit, control,
// ALU result and destination register.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RN_W   = DEF_RN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld,
  input  logic              take,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_alu,
  input  logic [RN_W-1:0]   d_rn,
  output logic              vld,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] alu,
  output logic [RN_W-1:0]   rn
);

  logic              vld_q, vld_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [RN_W-1:0]   rn_q, rn_d;

  // clr kills the entry but keeps the payload visible on the bus
  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    alu_d  = alu_q;
    rn_d   = rn_q;
    if (clr) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
    end else if (ld) begin
      vld_d  = 1'b1;
      ctrl_d = d_ctrl;
      alu_d  = d_alu;
      rn_d   = d_rn;
    end else if (take) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      alu_q  <= '0;
      rn_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      alu_q  <= alu_d;
      rn_q   <= rn_d;
    end
  end

  assign vld  = vld_q;
  assign ctrl = ctrl_q;
  assign alu  = alu_q;
  assign rn   = rn_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Stage boundary register with ready/valid handshake, flush,
// optional skid slot and saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RN_W   = DEF_RN_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wreg,
  input  logic              in_m2reg,
  input  logic              in_wmem,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [RN_W-1:0]   in_rn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wreg,
  output logic              out_m2reg,
  output logic              out_wmem,
  output logic [DATA_W-1:0] out_alu,
  output logic [RN_W-1:0]   out_rn,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_ctrl_t        in_c, m_c;
  logic              acc, drn;
  logic              m_vld, m_ld, m_src_s;
  logic [CTRL_W-1:0] m_ctrl, m_dctrl;
  logic [DATA_W-1:0] m_alu, m_dalu;
  logic [RN_W-1:0]   m_rn, m_drn;
  logic              s_vld;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_alu;
  logic [RN_W-1:0]   s_rn;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign in_c.wreg  = in_wreg;
  assign in_c.m2reg = in_m2reg;
  assign in_c.wmem  = in_wmem;

  // flush blocks both the accept and the drain of this cycle
  assign acc = in_valid && in_ready && !flush;
  assign drn = m_vld && out_ready && !flush;

  always_comb begin
    m_src_s = drn && s_vld;
    m_ld    = (acc && (!m_vld || drn)) || m_src_s;
    m_dctrl = m_src_s ? s_ctrl : in_c;
    m_dalu  = m_src_s ? s_alu : in_alu;
    m_drn   = m_src_s ? s_rn : in_rn;
  end

  pipe_slot #(.DATA_W(DATA_W), .RN_W(RN_W)) u_m (
    .clk    (clk),
    .rst    (rst),
    .clr    (flush),
    .ld     (m_ld),
    .take   (drn),
    .d_ctrl (m_dctrl),
    .d_alu  (m_dalu),
    .d_rn   (m_drn),
    .vld    (m_vld),
    .ctrl   (m_ctrl),
    .alu    (m_alu),
    .rn     (m_rn)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic s_ld, s_take;
      assign s_ld   = acc && m_vld && !drn;
      assign s_take = drn && s_vld;
      assign in_ready = !s_vld;

      pipe_slot #(.DATA_W(DATA_W), .RN_W(RN_W)) u_s (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .ld     (s_ld),
        .take   (s_take),
        .d_ctrl (in_c),
        .d_alu  (in_alu),
        .d_rn   (in_rn),
        .vld    (s_vld),
        .ctrl   (s_ctrl),
        .alu    (s_alu),
        .rn     (s_rn)
      );
    end else begin : g_noskid
      assign s_vld    = 1'b0;
      assign s_ctrl   = '0;
      assign s_alu    = '0;
      assign s_rn     = '0;
      assign in_ready = !m_vld || out_ready;
    end
  endgenerate

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_vld && !out_ready && !flush && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign m_c       = pipe_ctrl_t'(m_ctrl);
  assign out_valid = m_vld;
  assign out_wreg  = m_vld & m_c.wreg;
  assign out_m2reg = m_vld & m_c.m2reg;
  assign out_wmem  = m_vld & m_c.wmem;
  assign out_alu   = m_alu;
  assign out_rn    = m_rn;
  assign stall_cnt = stall_cnt_q;

endmodule
